// File: rtl/player_missile.sv
`default_nettype none
// player_missile: launches one missile from the player cannon, moves it up once per frame,
// retires it on hit or top exit, then holds a reload cooldown. Option macro: PLAYER_MISSILE_AUTO_FIRE_EN.
module player_missile #(
  parameter int FIRE_KEY        = 5,
  parameter int PLAYER_W        = 32,
  parameter int MISSILE_W       = 4,
  parameter int MISSILE_H       = 8,
  parameter int MISSILE_SPEED   = 8,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        restart,
  input  logic [3:0]  keyPad,
  input  logic        keyPadValid,
  input  logic        keyIsPressed,
  input  logic [10:0] playerTopLeftX,
  input  logic [10:0] playerTopLeftY,
  input  logic        hitDetected,
  output logic [10:0] missileTopLeftX,
  output logic [10:0] missileTopLeftY,
  output logic        missileActive,
  output logic        shotFired
);

  localparam logic [1:0] READY    = 2'd0;
  localparam logic [1:0] FLYING   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  logic [1:0]    state;
  logic          fire_prev;
  logic          fire_req;
  logic [CW-1:0] cool_cnt;

  logic fire_key;
  logic fire_set;
  logic launch;

  assign fire_key = keyPadValid & keyIsPressed & (keyPad == 4'(FIRE_KEY));

`ifdef PLAYER_MISSILE_AUTO_FIRE_EN
  assign fire_set = fire_key;
`else
  assign fire_set = fire_key & ~fire_prev;
`endif

  assign launch = (state == READY) & startOfFrame & fire_req;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state           <= READY;
      fire_prev       <= 1'b0;
      fire_req        <= 1'b0;
      cool_cnt        <= '0;
      missileTopLeftX <= '0;
      missileTopLeftY <= '0;
      missileActive   <= 1'b0;
      shotFired       <= 1'b0;
    end else begin
      fire_prev <= fire_key;
      shotFired <= 1'b0;
      case (state)
        READY: begin
          if (launch) begin
            missileTopLeftX <= playerTopLeftX + 11'(PLAYER_W / 2 - MISSILE_W / 2);
            missileTopLeftY <= playerTopLeftY - 11'(MISSILE_H);
            missileActive   <= 1'b1;
            shotFired       <= 1'b1;
            fire_req        <= 1'b0;
            state           <= FLYING;
          end else if (fire_set) begin
            fire_req <= 1'b1;
          end
        end
        FLYING: begin
          // A hit wins over the frame move so the drawn position matches the collision.
          if (hitDetected) begin
            missileActive <= 1'b0;
            cool_cnt      <= CW'(COOLDOWN_FRAMES);
            state         <= COOLDOWN;
          end else if (startOfFrame && (missileTopLeftY < 11'(MISSILE_SPEED))) begin
            missileActive <= 1'b0;
            cool_cnt      <= CW'(COOLDOWN_FRAMES);
            state         <= COOLDOWN;
          end else if (startOfFrame) begin
            missileTopLeftY <= missileTopLeftY - 11'(MISSILE_SPEED);
          end
        end
        COOLDOWN: begin
          if (cool_cnt == '0) begin
            state <= READY;
          end else if (startOfFrame) begin
            cool_cnt <= cool_cnt - 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_missile.sv
`default_nettype none
// tb_player_missile: directed launch vectors from a table plus hand-written flight,
// hit, cooldown, held-key, reset and restart sequences.
module tb_player_missile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  keyPad = 4'd0;
  logic        keyPadValid = 1'b0;
  logic        keyIsPressed = 1'b0;
  logic [10:0] playerTopLeftX = 11'd0;
  logic [10:0] playerTopLeftY = 11'd0;
  logic        hitDetected = 1'b0;
  logic [10:0] missileTopLeftX;
  logic [10:0] missileTopLeftY;
  logic        missileActive;
  logic        shotFired;

  int checks = 0;
  int errors = 0;
  int shots  = 0;

  player_missile dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .restart(restart),
    .keyPad(keyPad),
    .keyPadValid(keyPadValid),
    .keyIsPressed(keyIsPressed),
    .playerTopLeftX(playerTopLeftX),
    .playerTopLeftY(playerTopLeftY),
    .hitDetected(hitDetected),
    .missileTopLeftX(missileTopLeftX),
    .missileTopLeftY(missileTopLeftY),
    .missileActive(missileActive),
    .shotFired(shotFired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] px;
    logic [10:0] py;
    logic [3:0]  key;
    logic        valid;
    logic        pressed;
    logic        exp_launch;
    logic [10:0] ex;
    logic [10:0] ey;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs and samples land 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (shotFired) shots++;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic sofs(input int n);
    for (int i = 0; i < n; i++) begin
      sof();
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_key(input logic [3:0] k, input logic v, input logic p);
    keyPad = k;
    keyPadValid = v;
    keyIsPressed = p;
  endtask

  task automatic press_release();
    set_key(4'd5, 1'b1, 1'b1);
    tick();
    set_key(4'd5, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    vecs[0] = '{11'd320, 11'd450, 4'd5, 1'b1, 1'b1, 1'b1, 11'd334, 11'd442};
    vecs[1] = '{11'd0,   11'd8,   4'd5, 1'b1, 1'b1, 1'b1, 11'd14,  11'd0};
    vecs[2] = '{11'd639, 11'd479, 4'd5, 1'b1, 1'b1, 1'b1, 11'd653, 11'd471};
    vecs[3] = '{11'd320, 11'd450, 4'd4, 1'b1, 1'b1, 1'b0, 11'd0,   11'd0};
    vecs[4] = '{11'd320, 11'd450, 4'd5, 1'b0, 1'b1, 1'b0, 11'd0,   11'd0};
    vecs[5] = '{11'd320, 11'd450, 4'd5, 1'b1, 1'b0, 1'b0, 11'd0,   11'd0};

    tick();
    tick();
    check("reset_active", 32'(missileActive), 32'd0);
    check("reset_shot", 32'(shotFired), 32'd0);
    check("reset_x", 32'(missileTopLeftX), 32'd0);
    check("reset_y", 32'(missileTopLeftY), 32'd0);
    reset = 1'b0;
    tick();

    // Launch table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      playerTopLeftX = vecs[i].px;
      playerTopLeftY = vecs[i].py;
      set_key(vecs[i].key, vecs[i].valid, vecs[i].pressed);
      tick();
      set_key(vecs[i].key, vecs[i].valid, 1'b0);
      tick();
      sof();
      check($sformatf("vec%0d_shot", i), 32'(shotFired), 32'(vecs[i].exp_launch));
      check($sformatf("vec%0d_active", i), 32'(missileActive), 32'(vecs[i].exp_launch));
      check($sformatf("vec%0d_x", i), 32'(missileTopLeftX), 32'(vecs[i].ex));
      check($sformatf("vec%0d_y", i), 32'(missileTopLeftY), 32'(vecs[i].ey));
      tick();
      check($sformatf("vec%0d_shot_pulse", i), 32'(shotFired), 32'd0);
    end

    // Flight, X frozen, hit priority, cooldown discard and re-arm
    do_reset();
    playerTopLeftX = 11'd320;
    playerTopLeftY = 11'd450;
    press_release();
    sof();
    tick();
    playerTopLeftX = 11'd100;
    playerTopLeftY = 11'd200;
    sofs(10);
    check("fly10_y", 32'(missileTopLeftY), 32'd362);
    check("fly10_x", 32'(missileTopLeftX), 32'd334);
    check("fly10_active", 32'(missileActive), 32'd1);
    hitDetected = 1'b1;
    startOfFrame = 1'b1;
    tick();
    hitDetected = 1'b0;
    startOfFrame = 1'b0;
    check("hit_active", 32'(missileActive), 32'd0);
    check("hit_y_hold", 32'(missileTopLeftY), 32'd362);
    tick();
    playerTopLeftX = 11'd320;
    playerTopLeftY = 11'd450;
    shots = 0;
    sofs(14);
    press_release();
    sofs(1);
    tick();
    tick();
    sofs(2);
    check("cooldown_discard_shots", 32'(shots), 32'd0);
    check("cooldown_discard_active", 32'(missileActive), 32'd0);
    press_release();
    sof();
    check("rearm_shot", 32'(shotFired), 32'd1);
    check("rearm_y", 32'(missileTopLeftY), 32'd442);
    tick();

    // Top exit
    sofs(55);
    check("exit_y2", 32'(missileTopLeftY), 32'd2);
    check("exit_active_before", 32'(missileActive), 32'd1);
    sof();
    check("exit_active", 32'(missileActive), 32'd0);
    check("exit_y_hold", 32'(missileTopLeftY), 32'd2);
    tick();

    // Exact cooldown length after exit: a press with one frame left is discarded
    sofs(14);
    press_release();
    sofs(1);
    tick();
    shots = 0;
    sofs(1);
    check("exit_cool_reject", 32'(shots), 32'd0);
    press_release();
    sofs(1);
    check("exit_cool_accept", 32'(shots), 32'd1);

    // Held key through flight and cooldown
    do_reset();
    set_key(4'd5, 1'b1, 1'b1);
    tick();
    shots = 0;
    sofs(1);
    check("held_first_shot", 32'(shots), 32'd1);
    sofs(56);
    check("held_exit", 32'(missileActive), 32'd0);
    sofs(15);
    tick();
    shots = 0;
    sofs(1);
`ifdef PLAYER_MISSILE_AUTO_FIRE_EN
    check("held_refire", 32'(shots), 32'd1);
    sofs(60);
    tick();
`else
    check("held_no_refire", 32'(shots), 32'd0);
    sofs(2);
    check("held_no_refire_more", 32'(shots), 32'd0);
`endif
    set_key(4'd5, 1'b1, 1'b0);
    tick();
    shots = 0;
    press_release();
    sofs(1);
    check("held_repress_shot", 32'(shots), 32'd1);

    // Reset mid-flight
    sofs(3);
    reset = 1'b1;
    tick();
    check("midreset_active", 32'(missileActive), 32'd0);
    check("midreset_x", 32'(missileTopLeftX), 32'd0);
    check("midreset_y", 32'(missileTopLeftY), 32'd0);
    check("midreset_shot", 32'(shotFired), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    press_release();
    sof();
    check("post_reset_launch", 32'(shotFired), 32'd1);
    tick();

    // Restart mid-flight
    sofs(2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_active", 32'(missileActive), 32'd0);
    check("restart_y", 32'(missileTopLeftY), 32'd0);
    tick();
    shots = 0;
    sofs(1);
    check("restart_no_launch", 32'(shots), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_missile.md
Name: player_missile

Overview:
- Downstream consumer of the player movement stage's topLeftX/topLeftY.
- Launches one player missile from the cannon on a fire-key press and moves it up once per frame.
- Retires the missile on a collision or when it leaves the top of the screen, then enforces a reload cooldown.
- Outputs feed the missile drawing object and the collision logic.

Parameters:
- FIRE_KEY, 5, keypad code that fires.
- PLAYER_W, 32, player sprite width in pixels.
- MISSILE_W, 4, missile width in pixels.
- MISSILE_H, 8, missile height in pixels.
- MISSILE_SPEED, 8, pixels moved up per frame.
- COOLDOWN_FRAMES, 15, frames spent in COOLDOWN before re-arming.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- restart  in  1  synchronous game restart, same effect as reset.
- keyPad  in  4  keypad code.
- keyPadValid  in  1  keyPad holds a valid code.
- keyIsPressed  in  1  a key is held.
- playerTopLeftX  in  11  player X from the movement stage.
- playerTopLeftY  in  11  player Y from the movement stage.
- hitDetected  in  1  missile collided with an alien or shield; level-sensitive.
- missileTopLeftX  out  11  missile top-left X.
- missileTopLeftY  out  11  missile top-left Y.
- missileActive  out  1  missile is in flight (draw enable).
- shotFired  out  1  one-cycle pulse on launch (sound/score hook).

Behaviour:
- Reset and restart:
  - Evaluated every posedge clk; reset has priority over restart.
  - Both produce state=READY, fireReq=0, cooldown counter=0, missileTopLeftX/Y=0, missileActive=0, shotFired=0, fire-edge history=0.
  - Either input asserted mid-flight aborts the missile in the same cycle.
- Fire detect:
  - fireKey = keyPadValid & keyIsPressed & (keyPad==FIRE_KEY).
  - A 0->1 edge of fireKey, registered against its previous-cycle value, sets fireReq.
  - fireReq is cleared only by a launch, reset or restart.
  - An edge arriving in FLYING or COOLDOWN is discarded; fireReq is set only while in READY.
- READY:
  - On startOfFrame with fireReq=1, launch and go to FLYING.
  - Launch loads missileTopLeftX = playerTopLeftX + PLAYER_W/2 - MISSILE_W/2, missileTopLeftY = playerTopLeftY - MISSILE_H.
  - Launch sets missileActive=1, pulses shotFired for exactly that cycle, and clears fireReq.
  - Player coordinates are sampled in the launch cycle.
- FLYING, priority order each cycle:
  1. hitDetected=1 -> missileActive=0, go to COOLDOWN; Y is not updated even if startOfFrame is high.
  2. startOfFrame and missileTopLeftY < MISSILE_SPEED -> missileActive=0, go to COOLDOWN (off-screen exit).
  3. startOfFrame -> missileTopLeftY -= MISSILE_SPEED. X is frozen during flight.
- COOLDOWN:
  - Counter loads COOLDOWN_FRAMES on entry and decrements on each startOfFrame.
  - When the counter is 0 the next cycle goes to READY.
  - COOLDOWN_FRAMES=0 gives exactly one cycle in COOLDOWN.
- Coordinates hold their last value while missileActive=0; consumers gate on missileActive.
- Arithmetic is 11-bit unsigned.
  - X sum cannot overflow with player X in 0..639.
  - Y cannot underflow, because the exit check precedes the subtraction.
  - Launch requires playerTopLeftY >= MISSILE_H, which holds for all legal player positions.
- Only one missile exists at a time; a launch never occurs in the same cycle as a retire.

Optional Feature:
- Macro PLAYER_MISSILE_AUTO_FIRE_EN.
- When defined: fireReq is set by the fireKey level (not its edge) whenever state=READY, so holding the key re-fires automatically after each cooldown.
- When undefined: one shot per press; the key must be released and pressed again to re-fire.

Test Plan:
- Reset: assert reset 2 cycles mid-flight -> next cycle missileActive=0, X=Y=0, shotFired=0, state READY.
- Launch: player (320,450), key 5 pressed (valid) -> at next startOfFrame shotFired one cycle, missileActive=1, X=334, Y=442; after 10 more frames Y=362, X=334.
- Top exit: continue from launch with no hit -> Y=2 after 55 moves, missileActive=0 at the 56th frame; new press rejected for 15 frames, accepted after re-arm.
- Hit priority: hitDetected and startOfFrame in the same cycle at Y=362 -> missileActive=0, Y stays 362, state COOLDOWN.
- Held key: key 5 held through flight and cooldown (macro off) -> no second shotFired; release and press again -> new launch. With macro on -> second launch at the first startOfFrame after READY.
- Restart and wrong key: restart pulse mid-flight -> missileActive=0 next cycle; keyPad=4 or keyPadValid=0 -> no launch.
